issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Issue-control stage between `decode` and execute. It registers each decoded instruction into a single-entry issue register with valid/ready handshakes. A 32-entry register scoreboard stalls RAW and WAW hazards against in-flight writers. Serializing instructions (CSR*, FENCE/FENCE.I, ECALL/EBREAK/MRET/SRET/WFI) wait for the pipeline to drain, and nothing younger issues until they complete.

## Interface
Parameters:
- `MAX_INFLIGHT`, 4: maximum issued-but-not-retired instructions; range 1..15.
- `CNT_W`, `$clog2(MAX_INFLIGHT+1)`: width of the in-flight counter. Derived; do not override.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decoded instruction present.
- `in_ready`  out  1  stage accepts the instruction this cycle.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each  register indices from decode.
- `in_uses_rs1`, `in_uses_rs2`, `in_writes_rd`  in  1 each  operand and destination usage flags.
- `in_serial`  in  1  instruction is serializing.
- `in_payload`  in  64  one-hot Single_Instruction code; carried through unchanged.
- `out_valid`  out  1  issue register holds an instruction.
- `out_ready`  in  1  execute consumes the instruction.
- `out_rd`, `out_rs1`, `out_rs2`  out  5 each  registered copies of the inputs.
- `out_payload`  out  64  registered copy of `in_payload`.
- `wb_valid`  in  1  writeback event.
- `wb_rd`  in  5  register being written back.
- `retire`  in  1  one issued instruction completed.
- `i_flush`  in  1  squash the issue register.
- `busy_o`  out  32  scoreboard vector, for debug.

## Operation
- **Accept.** Accept occurs when `in_valid && in_ready`. On accept, the instruction loads into the issue register. If `in_writes_rd && in_rd!=0`, set `sb[in_rd]`.
- **`in_ready` conditions.** `in_ready` is high only when all of the following hold:
  - `!out_valid || out_ready`.
  - `state==RUN`.
  - No hazard.
  - `cnt + out_valid < MAX_INFLIGHT`.
  - If `in_serial`: `cnt==0` and `!out_valid`.
- **Hazard.** A hazard exists when any of the following holds:
  - `in_uses_rs1 && sb[in_rs1]`.
  - `in_uses_rs2 && sb[in_rs2]`.
  - `in_writes_rd && sb[in_rd]`.
- **Register x0.** x0 is never busy: `sb[0]` is hardwired to 0.
- **Fire and counter.** Fire occurs when `out_valid && out_ready`; it increments `cnt`. `retire` decrements `cnt`. Fire and retire in the same cycle leave `cnt` unchanged. `retire` with `cnt==0` is ignored and does not underflow.
- **Writeback.** `wb_valid` clears `sb[wb_rd]`. If a set and a clear hit the same index in the same cycle, the set wins.
- **State machine.** States are RUN, DRAIN and SERIAL.
  - RUN → DRAIN when `in_valid && in_serial` and the drain condition fails.
  - DRAIN → RUN when `cnt==0 && !out_valid`. The serial instruction is then accepted on a following cycle.
  - RUN → SERIAL on accept of a serial instruction.
  - SERIAL blocks all accepts. It exits to RUN on the cycle `retire` is seen with `cnt==1`, or with `cnt==0` if the instruction has not yet fired. That cycle's `cnt` then reaches 0.
- **Flush.** `i_flush` clears `out_valid`. If the squashed instruction set a scoreboard bit, that bit is cleared. `i_flush` also forces `state=RUN`. It does not touch `cnt` or other scoreboard bits, because fired instructions still retire. Flush has priority over a same-cycle accept: the accept is suppressed and `in_ready=0`.
- **Reset mid-operation.** Reset discards all state; no retire is expected afterwards.

## Timing
- Decode-to-issue latency is 1 cycle: an instruction accepted at edge N has `out_valid` high after edge N.
- Back-to-back independent instructions sustain 1 per cycle.
- A RAW dependence on a single-cycle writer stalls until the `wb_valid` edge, plus the bypass rules below.
- `out_*` hold stable while `out_valid && !out_ready`.
- Reset values: `out_valid=0`, `out_rd/rs1/rs2=0`, `out_payload=0`, `busy_o=0`, `cnt=0`, `state=RUN`. `in_ready` is combinational and therefore evaluates to 1 after reset, given `in_valid` non-serial.

## Configuration
- `ISSUE_WB_BYPASS_EN` defined: the hazard check uses `sb & ~({32{wb_valid}} & (1<<wb_rd))`, so a dependent instruction accepts in the same cycle as the writeback.
- Not defined: the hazard check uses the registered `sb` only, which adds one stall cycle after writeback. Retire does not bypass the serial or drain checks in either configuration.

## Structure
- The shared package `riscv_pkg` holds:
  - State encodings `ISS_RUN=2'd0`, `ISS_DRAIN=2'd1`, `ISS_SERIAL=2'd2`.
  - The existing `inst_*` one-hot codes.
  - A helper function `is_serial(payload)`, used by the decode glue to drive `in_serial`.
- Sub-module `issue_sb_regs`: 32-bit set/clear scoreboard with the set-wins rule, flush-clear port and x0 masking.

## Test plan
- **Reset.** Assert `i_rst` asynchronously mid-cycle → `out_valid=0` and `busy_o=0` immediately; `cnt=0`.
- **RAW stall.** ADD x5 then ADD x6,x5,x1, `out_ready=1`, `wb_valid` with `wb_rd=5` three cycles later → the second instruction accepts on that cycle with bypass, one cycle later without.
- **x0.** Writer to x0 followed by a reader of x0 → no stall; `busy_o[0]=0`.
- **Serialize.** Two in flight (`cnt=2`), then CSRRW presented → enter DRAIN. After two `retire` pulses the CSRRW is accepted, then SERIAL. The next ADDI waits until the CSRRW's `retire`.
- **Full.** `MAX_INFLIGHT=4` with no retire → exactly 4 fires, then `in_ready=0`. One `retire` allows exactly one more fire.
- **Flush.** Issue LW x7 held with `out_ready=0`, then `i_flush` → `out_valid=0` and `busy_o[7]=0`. A concurrent `in_valid` is not accepted.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared issue-stage types, one-hot instruction codes and serial classifier
//
// Purpose: issue FSM state encoding, the one-hot Single_Instruction codes
// carried as payload, and is_serial() used by the decode glue to drive in_serial.
// Ports: none (package).
package riscv_pkg;

  typedef enum logic [1:0] {
    ISS_RUN    = 2'd0,
    ISS_DRAIN  = 2'd1,
    ISS_SERIAL = 2'd2
  } iss_state_t;

  localparam int NUM_INST = 64;
  typedef logic [NUM_INST-1:0] inst_code_t;

  localparam inst_code_t inst_add     = 64'h1 << 0;
  localparam inst_code_t inst_sub     = 64'h1 << 1;
  localparam inst_code_t inst_addi    = 64'h1 << 2;
  localparam inst_code_t inst_lw      = 64'h1 << 3;
  localparam inst_code_t inst_sw      = 64'h1 << 4;
  localparam inst_code_t inst_beq     = 64'h1 << 5;
  localparam inst_code_t inst_jal     = 64'h1 << 6;
  localparam inst_code_t inst_lui     = 64'h1 << 7;
  localparam inst_code_t inst_csrrw   = 64'h1 << 8;
  localparam inst_code_t inst_csrrs   = 64'h1 << 9;
  localparam inst_code_t inst_csrrc   = 64'h1 << 10;
  localparam inst_code_t inst_csrrwi  = 64'h1 << 11;
  localparam inst_code_t inst_csrrsi  = 64'h1 << 12;
  localparam inst_code_t inst_csrrci  = 64'h1 << 13;
  localparam inst_code_t inst_fence   = 64'h1 << 14;
  localparam inst_code_t inst_fence_i = 64'h1 << 15;
  localparam inst_code_t inst_ecall   = 64'h1 << 16;
  localparam inst_code_t inst_ebreak  = 64'h1 << 17;
  localparam inst_code_t inst_mret    = 64'h1 << 18;
  localparam inst_code_t inst_sret    = 64'h1 << 19;
  localparam inst_code_t inst_wfi     = 64'h1 << 20;

  // Everything that must see an empty pipeline before and after it.
  localparam inst_code_t SERIAL_MASK =
      inst_csrrw | inst_csrrs | inst_csrrc | inst_csrrwi | inst_csrrsi |
      inst_csrrci | inst_fence | inst_fence_i | inst_ecall | inst_ebreak |
      inst_mret | inst_sret | inst_wfi;

  function automatic logic is_serial(input inst_code_t payload);
    return |(payload & SERIAL_MASK);
  endfunction

endpackage

// File: rtl/issue_sb_regs.sv
// rtl/issue_sb_regs.sv - 32-entry register busy scoreboard with set-wins and x0 masking
//
// Purpose: one busy bit per architectural register.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   set_en, set_idx          mark a register busy (new in-flight writer)
//   clr_en, clr_idx          writeback clear
//   flush_clr_en/idx         clear the bit owned by a squashed instruction
//   busy                     registered busy vector, bit 0 always 0
module issue_sb_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  input  logic        flush_clr_en,
  input  logic [4:0]  flush_clr_idx,
  output logic [31:0] busy
);

  logic [31:0] busy_next;

  // Clears first, set last, so a same-cycle set on the same index wins.
  always_comb begin
    busy_next = busy;
    if (clr_en)       busy_next[clr_idx]       = 1'b0;
    if (flush_clr_en) busy_next[flush_clr_idx] = 1'b0;
    if (set_en)       busy_next[set_idx]       = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - single-entry issue register with RAW/WAW scoreboard and serialization
//
// Purpose: registers decoded instructions toward execute, stalling on
// scoreboard hazards, the in-flight limit and serializing instructions.
// Optional feature macro: ISSUE_WB_BYPASS_EN (writeback clears the hazard in
// the same cycle instead of one cycle later).
// Ports:
//   i_clk, i_rst                      clock, asynchronous active-high reset
//   in_valid/in_ready                 decode handshake
//   in_rd/rs1/rs2, in_uses_*, in_writes_rd, in_serial, in_payload  instruction
//   out_valid/out_ready               execute handshake
//   out_rd/rs1/rs2, out_payload       issue register contents
//   wb_valid, wb_rd                   writeback clears a busy bit
//   retire                            one fired instruction completed
//   i_flush                           squash the issue register
//   busy_o                            scoreboard vector (debug)
module issue_scoreboard
  import riscv_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic        in_uses_rs1,
  input  logic        in_uses_rs2,
  input  logic        in_writes_rd,
  input  logic        in_serial,
  input  logic [63:0] in_payload,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [63:0] out_payload,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        retire,
  input  logic        i_flush,
  output logic [31:0] busy_o
);

  iss_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              out_wr;      // held instruction owns sb[out_rd]
  logic [31:0]       sb;
  logic [31:0]       sb_eff;
  logic              hazard;
  logic              drain_ok;
  logic              room_ok;
  logic              accept;
  logic              fire;
  logic              retire_eff;

`ifdef ISSUE_WB_BYPASS_EN
  logic [31:0] wb_mask;
  assign wb_mask = {32{wb_valid}} & (32'd1 << wb_rd);
  assign sb_eff  = sb & ~wb_mask;
`else
  assign sb_eff  = sb;
`endif

  assign hazard = (in_uses_rs1  && sb_eff[in_rs1]) ||
                  (in_uses_rs2  && sb_eff[in_rs2]) ||
                  (in_writes_rd && sb_eff[in_rd]);

  assign drain_ok = (cnt == '0) && !out_valid;

  // The held instruction is counted as if already fired so a fire plus a new
  // accept can never push the in-flight total past the limit.
  assign room_ok = (({1'b0, cnt} + (CNT_W+1)'(out_valid)) < (CNT_W+1)'(MAX_INFLIGHT));

  assign accept     = in_valid && in_ready;
  // A squashed instruction is not handed to execute, so it never counts.
  assign fire       = out_valid && out_ready && !i_flush;
  assign retire_eff = retire && (cnt != '0);

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ISS_RUN;
    else       state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (i_flush) begin
      state_next = ISS_RUN;
    end else begin
      case (state)
        ISS_RUN: begin
          if (accept && in_serial)                    state_next = ISS_SERIAL;
          else if (in_valid && in_serial && !drain_ok) state_next = ISS_DRAIN;
        end
        ISS_DRAIN:  if (drain_ok) state_next = ISS_RUN;
        // cnt==0 covers a retire seen before the serial instruction fired.
        ISS_SERIAL: if (retire && (cnt <= CNT_W'(1))) state_next = ISS_RUN;
        default:    state_next = ISS_RUN;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready = (!out_valid || out_ready) && (state == ISS_RUN) && !hazard &&
               room_ok && (!in_serial || drain_ok) && !i_flush;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else begin
      case ({fire, retire_eff})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid   <= 1'b0;
      out_wr      <= 1'b0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_payload <= '0;
    end else if (i_flush) begin
      out_valid <= 1'b0;
      out_wr    <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_wr      <= in_writes_rd && (in_rd != 5'd0);
      out_rd      <= in_rd;
      out_rs1     <= in_rs1;
      out_rs2     <= in_rs2;
      out_payload <= in_payload;
    end else if (fire) begin
      out_valid <= 1'b0;
      out_wr    <= 1'b0;
    end
  end

  issue_sb_regs u_sb (
    .clk           (i_clk),
    .rst           (i_rst),
    .set_en        (accept && in_writes_rd && (in_rd != 5'd0)),
    .set_idx       (in_rd),
    .clr_en        (wb_valid),
    .clr_idx       (wb_rd),
    .flush_clr_en  (i_flush && out_valid && out_wr),
    .flush_clr_idx (out_rd),
    .busy          (sb)
  );

  assign busy_o = sb;

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed and randomized self-checking bench for issue_scoreboard
module tb_issue_scoreboard;
  import riscv_pkg::*;

  localparam int MAXI = 4;
`ifdef ISSUE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        in_valid, in_uses_rs1, in_uses_rs2, in_writes_rd, in_serial;
  logic [4:0]  in_rd, in_rs1, in_rs2, wb_rd;
  logic [63:0] in_payload;
  logic        out_ready, wb_valid, retire, i_flush;
  logic        in_ready, out_valid;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [63:0] out_payload;
  logic [31:0] busy_o;

  issue_scoreboard #(.MAX_INFLIGHT(MAXI)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd),
    .in_serial(in_serial), .in_payload(in_payload),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_payload(out_payload),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .retire(retire), .i_flush(i_flush),
    .busy_o(busy_o)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a set of busy registers, a count of fired-but-unretired
  // instructions, the held instruction, and two behavioural flags.
  bit          m_busy [32];
  int          m_cnt;
  bit          m_hv, m_hwr;
  logic [4:0]  m_hrd, m_hrs1, m_hrs2;
  logic [63:0] m_hpay;
  bit          m_draining;      // a serial instruction waits for the pipe to empty
  bit          m_serial;        // a serial instruction is in the pipe

  bit dut_acc, dut_fire;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_cnt = 0; m_hv = 0; m_hwr = 0;
    m_hrd = '0; m_hrs1 = '0; m_hrs2 = '0; m_hpay = '0;
    m_draining = 0; m_serial = 0;
  endtask

  function automatic bit eff_busy(input logic [4:0] r);
    return m_busy[r] && !(BYP && wb_valid && (wb_rd == r));
  endfunction

  function automatic bit model_ready();
    bit haz;
    haz = (in_uses_rs1 && eff_busy(in_rs1)) || (in_uses_rs2 && eff_busy(in_rs2)) ||
          (in_writes_rd && eff_busy(in_rd));
    if (i_flush || m_draining || m_serial) return 1'b0;
    if (m_hv && !out_ready) return 1'b0;
    if (haz) return 1'b0;
    if (m_cnt + int'(m_hv) >= MAXI) return 1'b0;
    if (in_serial && (m_cnt != 0 || m_hv)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_busy();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_step(input bit acc, input bit fire);
    bit rt;
    rt = retire && (m_cnt > 0);
    if (i_flush) begin
      m_draining = 0; m_serial = 0;
    end else if (m_serial) begin
      if (retire && m_cnt <= 1) m_serial = 0;
    end else if (m_draining) begin
      if (m_cnt == 0 && !m_hv) m_draining = 0;
    end else if (acc && in_serial) begin
      m_serial = 1;
    end else if (in_valid && in_serial && (m_cnt != 0 || m_hv)) begin
      m_draining = 1;
    end
    if (fire && !rt) m_cnt++;
    else if (rt && !fire) m_cnt--;
    if (wb_valid) m_busy[wb_rd] = 1'b0;
    if (i_flush && m_hv && m_hwr) m_busy[m_hrd] = 1'b0;
    if (acc && in_writes_rd && in_rd != 0) m_busy[in_rd] = 1'b1;
    if (i_flush) m_hv = 0;
    else if (acc) begin
      m_hv = 1; m_hwr = in_writes_rd && (in_rd != 0);
      m_hrd = in_rd; m_hrs1 = in_rs1; m_hrs2 = in_rs2; m_hpay = in_payload;
    end else if (fire) m_hv = 0;
  endtask

  // Called at a falling edge with inputs already driven; compares, then
  // advances DUT and model through one rising edge.
  task automatic tick();
    bit exp_rdy, acc, fire;
    #1;
    exp_rdy = model_ready();
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_hv);
    chk("busy_o", busy_o, model_busy());
    if (m_hv) begin
      chk("out_rd", out_rd, m_hrd);
      chk("out_rs1", out_rs1, m_hrs1);
      chk("out_rs2", out_rs2, m_hrs2);
      chk("out_payload", out_payload, m_hpay);
    end
    dut_acc  = in_valid && in_ready;
    dut_fire = out_valid && out_ready;
    acc  = in_valid && exp_rdy;
    fire = m_hv && out_ready && !i_flush;
    @(posedge i_clk);
    model_step(acc, fire);
    @(negedge i_clk);
  endtask

  task automatic set_idle();
    in_valid = 0; in_uses_rs1 = 0; in_uses_rs2 = 0; in_writes_rd = 0; in_serial = 0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_payload = '0;
    out_ready = 1; wb_valid = 0; wb_rd = '0; retire = 0; i_flush = 0;
  endtask

  task automatic set_inst(input logic [63:0] code, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input bit u1, input bit u2, input bit wr);
    in_valid = 1; in_payload = code; in_serial = is_serial(code);
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_uses_rs1 = u1; in_uses_rs2 = u2; in_writes_rd = wr;
  endtask

  task automatic do_reset();
    set_idle();
    i_rst = 1;
    model_reset();
    repeat (2) @(negedge i_clk);
    i_rst = 0;
  endtask

  logic [63:0] codes [8];
  int acc_cyc, acc2_cyc, fires;

  initial begin
    codes = '{inst_add, inst_sub, inst_addi, inst_lw, inst_sw, inst_csrrw, inst_fence, inst_ecall};
    do_reset();

    // Reset values and combinational ready out of reset
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy_o, 32'd0);
    chk("rst_out_rd", out_rd, 5'd0);
    chk("rst_out_payload", out_payload, 64'd0);
    set_inst(inst_addi, 5'd0, 5'd1, 5'd0, 1, 0, 1);
    #1 chk("ready_after_reset", in_ready, 1'b1);
    tick();

    // x0 writer then x0 reader: no stall
    set_idle();
    set_inst(inst_add, 5'd4, 5'd0, 5'd0, 1, 1, 1);
    #1;
    chk("x0_ready", in_ready, 1'b1);
    chk("x0_busy0", busy_o[0], 1'b0);
    tick();

    // RAW: ADD x5 then ADD x6,x5,x1 with writeback of x5 on cycle 3
    do_reset();
    set_inst(inst_add, 5'd5, 5'd1, 5'd2, 1, 1, 1);
    tick();
    acc_cyc = -1;
    for (int c = 1; c <= 5; c++) begin
      set_idle();
      if (acc_cyc < 0) set_inst(inst_add, 5'd6, 5'd5, 5'd1, 1, 1, 1);
      wb_valid = (c == 3);
      wb_rd = 5'd5;
      tick();
      if (dut_acc && acc_cyc < 0) acc_cyc = c;
    end
    chk("raw_accept_cycle", acc_cyc, BYP ? 3 : 4);

    // Serialize: two in flight, CSRRW drains, then blocks the following ADDI
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_idle();
      set_inst(inst_add, 5'd0, 5'd1, 5'd2, 1, 1, 0);
      tick();
    end
    set_idle();
    tick();
    acc_cyc = -1;
    for (int c = 0; c < 10; c++) begin
      set_idle();
      if (acc_cyc < 0) set_inst(inst_csrrw, 5'd9, 5'd1, 5'd0, 1, 0, 1);
      retire = (c == 2 || c == 4);
      tick();
      if (dut_acc && acc_cyc < 0) acc_cyc = c;
    end
    chk("serial_accept_cycle", acc_cyc, 6);
    acc2_cyc = -1;
    for (int d = 0; d < 8; d++) begin
      set_idle();
      if (acc2_cyc < 0) set_inst(inst_addi, 5'd10, 5'd0, 5'd0, 1, 0, 1);
      retire = (d == 3);
      tick();
      if (dut_acc && acc2_cyc < 0) acc2_cyc = d;
    end
    chk("post_serial_accept_cycle", acc2_cyc, 4);

    // Full: exactly MAXI fires without retire, one more after a single retire
    do_reset();
    fires = 0;
    for (int c = 0; c < 12; c++) begin
      set_idle();
      set_inst(inst_add, 5'd0, 5'd1, 5'd2, 1, 1, 0);
      tick();
      fires += int'(dut_fire);
    end
    chk("full_fires", fires, MAXI);
    fires = 0;
    for (int c = 0; c < 8; c++) begin
      set_idle();
      set_inst(inst_add, 5'd0, 5'd1, 5'd2, 1, 1, 0);
      retire = (c == 0);
      tick();
      fires += int'(dut_fire);
    end
    chk("full_fires_after_retire", fires, 1);

    // Flush: held LW x7 squashed, concurrent decode not accepted
    do_reset();
    set_inst(inst_lw, 5'd7, 5'd1, 5'd0, 1, 0, 1);
    out_ready = 0;
    tick();
    set_idle();
    out_ready = 0;
    i_flush = 1;
    set_inst(inst_add, 5'd11, 5'd2, 5'd3, 1, 1, 1);
    #1 chk("flush_ready", in_ready, 1'b0);
    tick();
    #1;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_busy7", busy_o[7], 1'b0);
    set_idle();
    tick();

    // Asynchronous reset in the middle of a cycle
    set_idle();
    out_ready = 0;
    set_inst(inst_add, 5'd12, 5'd1, 5'd2, 1, 1, 1);
    tick();
    #2 i_rst = 1;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_busy", busy_o, 32'd0);
    model_reset();
    set_idle();
    @(negedge i_clk);
    i_rst = 0;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      set_idle();
      if ($urandom_range(0, 99) < 70) begin
        int k;
        k = ($urandom_range(0, 99) < 8) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
        set_inst(codes[k], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
      end
      out_ready = ($urandom_range(0, 99) < 75);
      wb_valid  = ($urandom_range(0, 99) < 30);
      wb_rd     = 5'($urandom_range(0, 7));
      retire    = ($urandom_range(0, 99) < 30);
      i_flush   = ($urandom_range(0, 99) < 3);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
